adc_scan_buffer: RTL
====================

ADC_SCAN_BUFFER -- requirements
Module: adc_scan_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: ADC sample width.
REQ-002 SHALL have parameter NUM_CH, default 4: number of ADC mux channels; CH_W = max(1, clog2(NUM_CH)).
REQ-003 SHALL have parameter DEPTH, default 64, power of two: FIFO entries.
REQ-004 SHALL have parameter BURST_LEN, default 64: samples captured per burst.
REQ-005 SHALL have ports, in order: sys_clk1 in 1, the single clock; reset in 1, asynchronous active-high.
REQ-006 SHALL have port start in 1: pulse that begins a burst.
REQ-007 SHALL have port continuous in 1: level that selects free-running scan.
REQ-008 SHALL have port ch_mask in NUM_CH: enabled channels.
REQ-009 SHALL have ports adc_channel out CH_W and adc_enable out 1: controller request.
REQ-010 SHALL have ports adc_data in DATA_W and adc_data_ready in 1: controller result; ready is a level.
REQ-011 SHALL have ports rd_en in 1 (pop), rd_data out DATA_W, rd_ch out CH_W and rd_valid out 1: FIFO head.
REQ-012 SHALL have ports fifo_count out clog2(DEPTH)+1, overflow out 1 (sticky), clear_ovf in 1, busy out 1 and done out 1 (pulse).

Function
REQ-013 SHALL implement FSM IDLE -> CONVERT -> CAPTURE -> ADVANCE -> CONVERT | IDLE.
REQ-014 IDLE SHALL go to CONVERT when (start or continuous) and ch_mask != 0; ch_mask == 0 SHALL hold IDLE and ignore start.
REQ-015 On leaving IDLE, adc_channel SHALL load the lowest set bit of ch_mask, and the burst counter SHALL clear.
REQ-016 adc_enable SHALL be 1 only in CONVERT; adc_channel SHALL stay stable while adc_enable = 1.
REQ-017 CONVERT SHALL go to CAPTURE on a rising edge of adc_data_ready (registered previous level); a ready level already high on entry SHALL NOT count.
REQ-018 CAPTURE SHALL last 1 cycle, write {adc_channel, adc_data} to the FIFO, and increment the burst counter.
REQ-019 ADVANCE SHALL last 1 cycle with adc_enable = 0, then select the next set ch_mask bit above the current channel, wrapping to the lowest set bit.
REQ-020 ch_mask SHALL be sampled in ADVANCE; if it is now 0, the FSM SHALL go to IDLE.
REQ-021 In burst mode (continuous = 0 at start), reaching BURST_LEN samples SHALL send ADVANCE to IDLE and pulse done for 1 cycle.
REQ-022 In continuous mode, BURST_LEN SHALL be ignored; continuous deasserting SHALL end the scan at the next ADVANCE -> IDLE, with done pulsed.
REQ-023 start while busy SHALL be ignored; busy SHALL = (state != IDLE).
REQ-024 FIFO SHALL be show-ahead: rd_valid = !empty, rd_data/rd_ch = head entry, and rd_en with rd_valid pops in 1 cycle.
REQ-025 rd_en while empty SHALL be ignored.
REQ-026 A write when full without a simultaneous pop SHALL be dropped, set overflow, and still count toward BURST_LEN.
REQ-027 A write and a pop in the same cycle when full SHALL both succeed, leaving fifo_count unchanged.
REQ-028 A write and a pop in the same cycle when empty SHALL only write.
REQ-029 Pointers SHALL wrap modulo DEPTH, and fifo_count SHALL range 0..DEPTH.
REQ-030 clear_ovf SHALL clear overflow next cycle; a coincident overflow event SHALL win (stays 1).

Reset
REQ-031 Reset SHALL asynchronously force IDLE, adc_enable 0, adc_channel 0, pointers/count 0, rd_valid 0, overflow 0, busy 0 and done 0; FIFO storage SHALL NOT be reset.
REQ-032 Reset mid-CONVERT SHALL drop adc_enable the same instant, with no partial write.

Structure
REQ-033 Package adc_scan_pkg SHALL hold the FSM state enum, the entry struct {ch, data} and the CH_W/count-width helper functions.
REQ-034 FIFO SHALL be sub-module adc_scan_fifo (parametrised width/depth, show-ahead, full/empty/count); the FSM and channel arbiter SHALL stay in adc_scan_buffer.

Verification
REQ-035 Burst of 4 samples on ch_mask = 4'b1010 with start pulse -> channels 1,3,1,3 captured in order, then done pulse, adc_enable 0, fifo_count = 4.
REQ-036 ready held high at CONVERT entry then low->high once -> exactly 1 sample written.
REQ-037 DEPTH = 4, no reads, burst 6 -> fifo_count = 4, overflow = 1, first 4 samples retained; clear_ovf -> overflow = 0.
REQ-038 Full FIFO with rd_en coincident with CAPTURE -> count stays 4, head advances, new sample is the tail, overflow = 0.
REQ-039 continuous = 1 on mask 4'b0001, then deassert mid-CONVERT -> that sample is stored, then IDLE with done pulsed.
REQ-040 reset asserted during CONVERT -> adc_enable 0 asynchronously, fifo_count 0, state IDLE; start pulse then restarts normally.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared types and sizing helpers for the ADC scan buffer.
package adc_scan_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    CAPTURE = 2'd2,
    ADVANCE = 2'd3
  } scanState_t;

  // Widest channel index / sample the entry view can carry.
  localparam int unsigned ENTRY_CH_MAX   = 8;
  localparam int unsigned ENTRY_DATA_MAX = 32;

  // One buffered sample tagged with the mux channel it came from.
  typedef struct packed {
    logic [ENTRY_CH_MAX-1:0]   ch;
    logic [ENTRY_DATA_MAX-1:0] data;
  } scanEntry_t;

  // Channel index width; a single-channel build still gets one bit.
  function automatic int unsigned chWidth(input int unsigned numCh);
    return (numCh <= 1) ? 1 : $clog2(numCh);
  endfunction

  // Occupancy counter width, able to hold 0..depth inclusive.
  function automatic int unsigned countWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_scan_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible without a pop.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module adc_scan_fifo
  import adc_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = countWidth(DEPTH)
) (
  input  logic             sys_clk1,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtrQ;
  logic [AW-1:0]    rdPtrQ;
  logic [CNT_W-1:0] countQ;
  logic [CNT_W-1:0] countNext;
  logic             fullQ;
  logic             emptyQ;
  logic             doPush;
  logic             doPop;

  // A pop needs data; a push needs room, or a pop freeing a slot this cycle.
  always_comb begin
    doPop     = rdEn && !emptyQ;
    doPush    = wrEn && (!fullQ || doPop);
    countNext = countQ + CNT_W'(doPush) - CNT_W'(doPop);
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge sys_clk1 or posedge reset) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      fullQ  <= 1'b0;
      emptyQ <= 1'b1;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + AW'(1);
      if (doPop)  rdPtrQ <= rdPtrQ + AW'(1);
      countQ <= countNext;
      fullQ  <= (countNext == CNT_W'(DEPTH));
      emptyQ <= (countNext == '0);
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge sys_clk1) begin
    if (doPush) mem[wrPtrQ] <= wrData;
  end

  assign rdData = mem[rdPtrQ];
  assign full   = fullQ;
  assign empty  = emptyQ;
  assign count  = countQ;

endmodule

// File: rtl/adc_scan_buffer.sv
// Scans the enabled ADC mux channels in ascending order, one conversion per
// channel, and buffers {channel, sample} pairs in a show-ahead FIFO.
module adc_scan_buffer
  import adc_scan_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BURST_LEN = 64,
  localparam int unsigned CH_W     = chWidth(NUM_CH),
  localparam int unsigned CNT_W    = countWidth(DEPTH)
) (
  input  logic              sys_clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [CH_W-1:0]   adc_channel,
  output logic              adc_enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_data_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CH_W-1:0]   rd_ch,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              clear_ovf,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);
  localparam int unsigned ENTRY_W = CH_W + DATA_W;

  scanState_t         stateQ;
  scanState_t         stateNext;
  logic [CH_W-1:0]    chQ;
  logic [CH_W-1:0]    chNext;
  logic [CH_W-1:0]    lowestCh;
  logic [CH_W-1:0]    nextCh;
  logic               foundAbove;
  logic [BURST_W-1:0] burstCntQ;
  logic               burstClr;
  logic               burstInc;
  logic               contModeQ;
  logic               modeNext;
  logic               readyPrevQ;
  logic               readyRise;
  logic               scanEnd;
  logic               enableQ;
  logic               busyQ;
  logic               doneQ;
  logic               doneSet;
  logic               ovfQ;
  logic               wrEn;
  logic               dropEvt;
  logic [ENTRY_W-1:0] fifoWrData;
  logic [ENTRY_W-1:0] fifoHead;
  logic               fifoFull;
  logic               fifoEmpty;

  // Channel arbiter: lowest enabled channel, and next enabled one above the current.
  always_comb begin
    lowestCh   = '0;
    nextCh     = '0;
    foundAbove = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lowestCh = CH_W'(i);
        if (i > int'(chQ)) begin
          nextCh     = CH_W'(i);
          foundAbove = 1'b1;
        end
      end
    end
    if (!foundAbove) nextCh = lowestCh;
  end

  // Only a low-to-high transition seen while converting completes a conversion.
  assign readyRise = adc_data_ready && !readyPrevQ;

  // Burst mode ends on sample count; free-running mode ends when continuous drops.
  assign scanEnd = contModeQ ? !continuous : (burstCntQ == BURST_W'(BURST_LEN));

  // Sequencer state register.
  always_ff @(posedge sys_clk1 or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  // Next-state, channel selection and burst bookkeeping.
  always_comb begin
    stateNext = stateQ;
    chNext    = chQ;
    modeNext  = contModeQ;
    burstClr  = 1'b0;
    burstInc  = 1'b0;
    doneSet   = 1'b0;
    wrEn      = 1'b0;
    case (stateQ)
      IDLE: begin
        if ((start || continuous) && (ch_mask != '0)) begin
          stateNext = CONVERT;
          chNext    = lowestCh;
          modeNext  = continuous;
          burstClr  = 1'b1;
        end
      end
      CONVERT: begin
        if (readyRise) stateNext = CAPTURE;
      end
      CAPTURE: begin
        wrEn      = 1'b1;
        burstInc  = 1'b1;
        stateNext = ADVANCE;
      end
      ADVANCE: begin
        if (scanEnd) begin
          stateNext = IDLE;
          doneSet   = 1'b1;
        end else if (ch_mask == '0) begin
          stateNext = IDLE;
        end else begin
          stateNext = CONVERT;
          chNext    = nextCh;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered request/status outputs and scan context.
  always_ff @(posedge sys_clk1 or posedge reset) begin
    if (reset) begin
      chQ        <= '0;
      contModeQ  <= 1'b0;
      readyPrevQ <= 1'b0;
      enableQ    <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      burstCntQ  <= '0;
    end else begin
      chQ        <= chNext;
      contModeQ  <= modeNext;
      readyPrevQ <= adc_data_ready;
      enableQ    <= (stateNext == CONVERT);
      busyQ      <= (stateNext != IDLE);
      doneQ      <= doneSet;
      if (burstClr)      burstCntQ <= '0;
      else if (burstInc) burstCntQ <= burstCntQ + BURST_W'(1);
    end
  end

  // A capture into a full FIFO with no pop in the same cycle is lost.
  assign dropEvt = wrEn && fifoFull && !rd_en;

  // Sticky overflow; a fresh drop outranks a clear in the same cycle.
  always_ff @(posedge sys_clk1 or posedge reset) begin
    if (reset)          ovfQ <= 1'b0;
    else if (dropEvt)   ovfQ <= 1'b1;
    else if (clear_ovf) ovfQ <= 1'b0;
  end

  assign fifoWrData = {chQ, adc_data};

  adc_scan_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .sys_clk1 (sys_clk1),
    .reset    (reset),
    .wrEn     (wrEn),
    .wrData   (fifoWrData),
    .rdEn     (rd_en),
    .rdData   (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifo_count)
  );

  assign adc_channel = chQ;
  assign adc_enable  = enableQ;
  assign busy        = busyQ;
  assign done        = doneQ;
  assign overflow    = ovfQ;
  assign rd_valid    = !fifoEmpty;
  assign rd_data     = fifoHead[DATA_W-1:0];
  assign rd_ch       = fifoHead[DATA_W +: CH_W];

endmodule
